// File: rtl/usb3_ep_pkg.sv
// Shared widths, state encoding and byte-enable helper for the USB3 endpoint reader.
package usb3_ep_pkg;

   localparam int unsigned EP_ADDR_W = 10;
   localparam int unsigned EP_DATA_W = 32;
   localparam int unsigned EP_LEN_W  = 13;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      ZLP,
      DRAIN
   } ep_state_t;

   // Byte enables of the final beat, chosen by the residual byte count.
   function automatic logic [3:0] last_be(input logic [1:0] len_lo);
      logic [3:0] be;
      unique case (len_lo)
         2'd0: be = 4'b1111;
         2'd1: be = 4'b0001;
         2'd2: be = 4'b0011;
         2'd3: be = 4'b0111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/usb3_ep_rd_fifo.sv
// Two-entry synchronous FIFO carrying {data, byte enables, last} beats.
module usb3_ep_rd_fifo #(
   parameter int unsigned WIDTH = 37
) (
   input  logic             rd_clk,
   input  logic             rd_rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is accepted when a pop frees the slot on the same edge.
   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge rd_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/usb3_ep_reader.sv
// Endpoint RAM read sequencer: turns (base, length) commands into a valid/ready beat stream.
module usb3_ep_reader
   import usb3_ep_pkg::*;
#(
   parameter int unsigned ADDR_W = EP_ADDR_W,
   parameter int unsigned DATA_W = EP_DATA_W,
   parameter int unsigned LEN_W  = EP_LEN_W
) (
   input  logic              rd_clk,
   input  logic              rd_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic [ADDR_W-1:0] ram_adr,
   input  logic [DATA_W-1:0] ram_dat,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        out_be,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int unsigned WL_W      = ADDR_W + 1;
   localparam int unsigned MAX_WORDS = 1 << ADDR_W;
   localparam int unsigned FW        = DATA_W + 5;

   ep_state_t       state;
   logic [WL_W-1:0] words_left;
   logic [1:0]      len_lo;
   logic            inflight;
   logic [3:0]      inflight_be;
   logic            inflight_last;

   logic [1:0]      fifo_count;
   logic            fifo_push;
   logic            fifo_pop;
   logic [FW-1:0]   fifo_din;
   logic [FW-1:0]   fifo_dout;

   logic [2:0]      credit;
   logic            issue;
   logic            fetch_last;
   logic [3:0]      fetch_be;
   logic [LEN_W:0]  len_words;
   logic [WL_W-1:0] cmd_words;

   always_comb begin
      len_words = ({1'b0, cmd_len} + (LEN_W+1)'(3)) >> 2;
      if (32'(len_words) > MAX_WORDS) begin
         cmd_words = WL_W'(MAX_WORDS);
      end else begin
         cmd_words = WL_W'(len_words);
      end
   end

   assign out_valid = (fifo_count != 2'd0);
   assign fifo_pop  = out_valid & out_ready;
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // Occupancy after this edge; one more fetch is allowed only if it will still have a slot.
   assign credit     = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, fifo_pop};
   assign issue      = (state == FETCH) && (words_left != '0) && (credit < 3'd2);
   assign fetch_last = (words_left == WL_W'(1));
   assign fetch_be   = fetch_last ? last_be(len_lo) : 4'b1111;

   assign fifo_push = inflight | (state == ZLP);
   assign fifo_din  = inflight ? {ram_dat, inflight_be, inflight_last}
                               : {{DATA_W{1'b0}}, 4'b0000, 1'b1};
   assign {out_data, out_be, out_last} = fifo_dout;

   usb3_ep_rd_fifo #(
      .WIDTH (FW)
   ) u_fifo (
      .rd_clk (rd_clk),
      .rd_rst (rd_rst),
      .push   (fifo_push),
      .din    (fifo_din),
      .pop    (fifo_pop),
      .dout   (fifo_dout),
      .count  (fifo_count)
   );

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state         <= IDLE;
         ram_adr       <= '0;
         words_left    <= '0;
         len_lo        <= '0;
         inflight      <= 1'b0;
         inflight_be   <= '0;
         inflight_last <= 1'b0;
         done          <= 1'b0;
      end else begin
         done     <= 1'b0;
         inflight <= issue;
         if (issue) begin
            inflight_be   <= fetch_be;
            inflight_last <= fetch_last;
            ram_adr       <= ram_adr + ADDR_W'(1);
            words_left    <= words_left - WL_W'(1);
         end
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  ram_adr    <= cmd_base;
                  words_left <= cmd_words;
                  len_lo     <= cmd_len[1:0];
                  state      <= (cmd_len == '0) ? ZLP : FETCH;
               end
            end
            FETCH: begin
               if (issue && fetch_last) begin
                  state <= DRAIN;
               end
            end
            ZLP: begin
               state <= DRAIN;
            end
            DRAIN: begin
               // The last-flagged beat is always the final entry, so its acceptance empties the pipe.
               if (done) begin
                  state <= IDLE;
               end else if (fifo_pop && out_last) begin
                  done <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb3_ep_reader.sv
// Self-checking bench for usb3_ep_reader: queue-based beat model plus pinned literal expectations.
module tb_usb3_ep_reader;

   logic        rd_clk = 1'b0;
   logic        rd_rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [9:0]  cmd_base = '0;
   logic [12:0] cmd_len = '0;
   logic [9:0]  ram_adr;
   logic [31:0] ram_dat = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic [3:0]  out_be;
   logic        out_last;
   logic        busy;
   logic        done;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  be;
      logic        last;
   } beat_t;

   typedef struct {
      int          beats;
      logic [31:0] first_d;
      logic [31:0] last_d;
      logic [3:0]  last_be;
      int          span;
   } pkt_t;

   logic [31:0] mem [1024];
   beat_t       exp_q [$];
   pkt_t        pkt_q [$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          ready_mode = 0;
   int          acc_cyc = 0;

   usb3_ep_reader #(
      .ADDR_W (10),
      .DATA_W (32),
      .LEN_W  (13)
   ) dut (
      .rd_clk    (rd_clk),
      .rd_rst    (rd_rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_base  (cmd_base),
      .cmd_len   (cmd_len),
      .ram_adr   (ram_adr),
      .ram_dat   (ram_dat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_be    (out_be),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 rd_clk = ~rd_clk;

   always @(posedge rd_clk) cyc <= cyc + 1;

   // Endpoint RAM with a registered read address.
   always @(posedge rd_clk) ram_dat <= mem[ram_adr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
   end

   initial forever begin
      @(posedge rd_clk);
      #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else out_ready = ~out_ready;
   end

   // Per-cycle compare against the expected-beat queue.
   initial begin
      logic        prev_last_acc;
      logic        hold;
      logic [31:0] h_d;
      logic [3:0]  h_be;
      logic        h_last;
      pkt_t        cur;
      beat_t       e;
      prev_last_acc = 1'b0;
      hold = 1'b0;
      h_d = '0; h_be = '0; h_last = 1'b0;
      cur = '{0, 32'h0, 32'h0, 4'h0, 0};
      forever begin
         @(negedge rd_clk);
         if (rd_rst) begin
            prev_last_acc = 1'b0;
            hold = 1'b0;
            cur.beats = 0;
         end else begin
            check("done_timing", done, prev_last_acc);
            if (done) done_cnt++;
            check("busy_vs_cmd_ready", busy, !cmd_ready);
            if (hold) check("valid_held_in_stall", out_valid, 1'b1);
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got data %0h be %0h last %0b, required no beat", out_data, out_be, out_last);
               end else begin
                  e = exp_q[0];
                  check("beat_data", out_data, e.d);
                  check("beat_be", out_be, e.be);
                  check("beat_last", out_last, e.last);
               end
               if (hold) begin
                  check("stall_data", out_data, h_d);
                  check("stall_be", out_be, h_be);
                  check("stall_last", out_last, h_last);
               end
               if (out_ready) begin
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
                  if (cur.beats == 0) begin
                     cur.first_d = out_data;
                     cur.span = cyc;
                  end
                  cur.beats++;
                  if (out_last) begin
                     cur.last_d = out_data;
                     cur.last_be = out_be;
                     cur.span = cyc - cur.span;
                     pkt_q.push_back(cur);
                     cur.beats = 0;
                  end
                  prev_last_acc = out_last;
                  hold = 1'b0;
               end else begin
                  hold = 1'b1;
                  h_d = out_data; h_be = out_be; h_last = out_last;
                  prev_last_acc = 1'b0;
               end
            end else begin
               prev_last_acc = 1'b0;
               hold = 1'b0;
            end
         end
      end
   end

   task automatic send_cmd(input int base, input int len);
      int guard = 0;
      int words;
      while (!cmd_ready && guard < 3000) begin
         @(posedge rd_clk);
         #1;
         guard++;
      end
      check("cmd_ready_wait", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_base = 10'(base);
      cmd_len = 13'(len);
      if (len == 0) begin
         exp_q.push_back('{32'h0, 4'b0000, 1'b1});
      end else begin
         words = (len + 3) / 4;
         if (words > 1024) words = 1024;
         for (int w = 0; w < words; w++) begin
            int r;
            r = len % 4;
            if (w == words - 1)
               exp_q.push_back('{mem[(base + w) % 1024], (r == 0) ? 4'hF : 4'((1 << r) - 1), 1'b1});
            else
               exp_q.push_back('{mem[(base + w) % 1024], 4'hF, 1'b0});
         end
      end
      @(posedge rd_clk);
      #1;
      cmd_valid = 1'b0;
      acc_cyc = cyc;
      check("adr_after_accept", ram_adr, 64'(base));
   endtask

   task automatic wait_idle(input int limit);
      int guard = 0;
      while (!(exp_q.size() == 0 && cmd_ready) && guard < limit) begin
         @(posedge rd_clk);
         #1;
         guard++;
      end
      check("packet_completes", exp_q.size() == 0 && cmd_ready, 1'b1);
   endtask

   task automatic check_pkt(input string name, input int beats, input logic [31:0] fd,
                            input logic [31:0] ld, input logic [3:0] lbe);
      pkt_t p;
      if (pkt_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_present: got no packet, required one", name);
      end else begin
         p = pkt_q.pop_front();
         check({name, "_beats"}, p.beats, beats);
         check({name, "_first_data"}, p.first_d, fd);
         check({name, "_last_data"}, p.last_d, ld);
         check({name, "_last_be"}, p.last_be, lbe);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin
      int lat;
      int d0;
      pkt_t p;

      repeat (2) @(posedge rd_clk);
      #1;
      rd_rst = 1'b0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_ram_adr", ram_adr, 64'd0);

      // base 0, len 16, streaming
      d0 = done_cnt;
      send_cmd(0, 16);
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge rd_clk);
         if (out_valid) begin
            lat = cyc - acc_cyc;
            break;
         end
      end
      check("first_beat_latency", 64'(lat), 64'd2);
      @(posedge rd_clk);
      #1;
      wait_idle(100);
      check("t1_done_count", done_cnt - d0, 1);
      if (pkt_q.size() != 0) begin
         p = pkt_q[0];
         check("t1_consecutive_span", p.span, 3);
      end
      check_pkt("t1", 4, 32'hC0DE0000, 32'hC0DE0003, 4'b1111);

      // wrap from 1022, len 13
      send_cmd(1022, 13);
      wait_idle(100);
      check_pkt("t2", 4, 32'hC0DE03FE, 32'hC0DE0001, 4'b0001);

      // zero-length packet
      d0 = done_cnt;
      send_cmd(7, 0);
      wait_idle(100);
      check("t3_done_count", done_cnt - d0, 1);
      check_pkt("t3", 1, 32'h0, 32'h0, 4'b0000);

      // full 4096-byte packet with toggling ready
      ready_mode = 1;
      send_cmd(500, 4096);
      wait_idle(6000);
      ready_mode = 0;
      check_pkt("t4", 1024, 32'hC0DE01F4, 32'hC0DE01F3, 4'b1111);

      // back-to-back commands
      d0 = done_cnt;
      send_cmd(40, 6);
      send_cmd(60, 3);
      wait_idle(100);
      check("t5_done_count", done_cnt - d0, 2);
      check_pkt("t5a", 2, 32'hC0DE0028, 32'hC0DE0029, 4'b0011);
      check_pkt("t5b", 1, 32'hC0DE003C, 32'hC0DE003C, 4'b0111);

      // reset in the middle of a fetch
      d0 = done_cnt;
      send_cmd(100, 64);
      repeat (3) @(posedge rd_clk);
      #1;
      rd_rst = 1'b1;
      @(posedge rd_clk);
      #1;
      rd_rst = 1'b0;
      exp_q.delete();
      pkt_q.delete();
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_cmd_ready", cmd_ready, 1'b1);
      repeat (6) @(posedge rd_clk);
      #1;
      check("midrst_no_done", done_cnt - d0, 0);
      send_cmd(5, 8);
      wait_idle(100);
      check_pkt("t6", 2, 32'hC0DE0005, 32'hC0DE0006, 4'b1111);

      repeat (3) @(posedge rd_clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
